// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: drives the data-memory req/ack port, aligns store lanes,
// extracts and extends load data, stalls on slow memory and owns the MEM/WB register.
module mem_access_stage #(
    parameter logic [6:0]  LOAD_OP = 7'b0000011,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [6:0]  EM_op_out,
    input  logic [2:0]  EM_funct3_out,
    input  logic [31:0] EM_daddr_out,
    input  logic [3:0]  EM_we_out,
    input  logic        EM_wer_out,
    input  logic [4:0]  EM_rd_out,
    input  logic [31:0] EM_regdata_out,
    input  logic [31:0] EM_dwdata_out,

    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,

    output logic        mem_stall,
    output logic        bus_err,

    output logic        MW_wer_out,
    output logic [4:0]  MW_rd_out,
    output logic [31:0] MW_regdata_out
);

    localparam logic [0:0] StIdle     = 1'b0;
    localparam logic [0:0] StWait     = 1'b1;
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    logic [0:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        mw_wer_q, mw_wer_d;
    logic [4:0]  mw_rd_q, mw_rd_d;
    logic [31:0] mw_data_q, mw_data_d;

    logic        is_store;
    logic        is_load;
    logic        mem_op;
    logic [1:0]  off;
    logic [3:0]  load_mask;
    logic [3:0]  acc_mask;
    logic [6:0]  shifted_mask;
    logic        misaligned;
    logic        active_state;
    logic        timeout_hit;
    logic [31:0] rdata_sh;
    logic [31:0] load_result;

    // Access decode and lane alignment
    always_comb begin
        is_store = |EM_we_out;
        is_load  = (EM_op_out == LOAD_OP) & EM_wer_out;
        mem_op   = is_load | is_store;
        off      = EM_daddr_out[1:0];

        case (EM_funct3_out)
            3'b000, 3'b100: load_mask = 4'b0001;
            3'b001, 3'b101: load_mask = 4'b0011;
            default:        load_mask = 4'b1111;
        endcase

        acc_mask     = is_store ? EM_we_out : load_mask;
        shifted_mask = {3'b000, acc_mask} << off;
        // Any lane pushed past byte 3 means the access straddles a word
        misaligned   = mem_op & (|shifted_mask[6:4]);
    end

    always_comb begin
        active_state = (state_q == StIdle) | (state_q == StWait);

        dmem_req   = rst_n & mem_op & ~misaligned & active_state;
        dmem_addr  = {EM_daddr_out[31:2], 2'b00};
        dmem_we    = is_store;
        dmem_be    = shifted_mask[3:0];
        dmem_wdata = EM_dwdata_out << {off, 3'b000};

        timeout_hit = (state_q == StWait) & dmem_req & ~dmem_ack & (wait_cnt_q == TimeoutCnt);
        mem_stall   = dmem_req & ~dmem_ack & ~timeout_hit;
        bus_err_d   = misaligned | timeout_hit;
    end

    // Load extraction: the addressed byte/half is moved down to bit 0 first
    always_comb begin
        rdata_sh = dmem_rdata >> {off, 3'b000};
        case (EM_funct3_out)
            3'b000:  load_result = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b100:  load_result = {24'h000000, rdata_sh[7:0]};
            3'b001:  load_result = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b101:  load_result = {16'h0000, rdata_sh[15:0]};
            default: load_result = rdata_sh;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StIdle: begin
                wait_cnt_d = 8'd0;
                if (dmem_req && !dmem_ack) begin
                    state_d    = StWait;
                    wait_cnt_d = 8'd1;
                end
            end
            StWait: begin
                if (!dmem_req || dmem_ack || timeout_hit) begin
                    state_d    = StIdle;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        mw_wer_d  = mw_wer_q;
        mw_rd_d   = mw_rd_q;
        mw_data_d = mw_data_q;
        if (!mem_stall) begin
            mw_wer_d  = EM_wer_out & ~misaligned & ~timeout_hit;
            mw_rd_d   = EM_rd_out;
            mw_data_d = (is_load & ~is_store) ? load_result : EM_regdata_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
            mw_wer_q   <= 1'b0;
            mw_rd_q    <= 5'd0;
            mw_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
            mw_wer_q   <= mw_wer_d;
            mw_rd_q    <= mw_rd_d;
            mw_data_q  <= mw_data_d;
        end
    end

    assign bus_err        = bus_err_q;
    assign MW_wer_out     = mw_wer_q;
    assign MW_rd_out      = mw_rd_q;
    assign MW_regdata_out = mw_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized transactions checked
// against a byte-level behavioural model of loads, stores and the wait/timeout budget.
module tb_mem_access_stage;

    localparam logic [6:0] LoadOp  = 7'b0000011;
    localparam logic [6:0] AluOp   = 7'b0110011;
    localparam logic [6:0] StoreOp = 7'b0100011;
    localparam int         Timeout = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  em_op;
    logic [2:0]  em_f3;
    logic [31:0] em_addr;
    logic [3:0]  em_we;
    logic        em_wer;
    logic [4:0]  em_rd;
    logic [31:0] em_regdata;
    logic [31:0] em_dwdata;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        bus_err;
    logic        mw_wer;
    logic [4:0]  mw_rd;
    logic [31:0] mw_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_stage #(
        .LOAD_OP (LoadOp),
        .TIMEOUT (Timeout)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .EM_op_out      (em_op),
        .EM_funct3_out  (em_f3),
        .EM_daddr_out   (em_addr),
        .EM_we_out      (em_we),
        .EM_wer_out     (em_wer),
        .EM_rd_out      (em_rd),
        .EM_regdata_out (em_regdata),
        .EM_dwdata_out  (em_dwdata),
        .dmem_req       (dmem_req),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .mem_stall      (mem_stall),
        .bus_err        (bus_err),
        .MW_wer_out     (mw_wer),
        .MW_rd_out      (mw_rd),
        .MW_regdata_out (mw_data)
    );

    always #5 clk = ~clk;

    // Reference: pick the addressed bytes out of the word and extend per funct3
    function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                             input logic [2:0] f3);
        logic [31:0] w;
        w = word >> (8 * off);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic int load_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    task automatic set_em(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [3:0] we, input logic wer, input logic [4:0] rd,
                          input logic [31:0] regdata, input logic [31:0] dwdata);
        em_op      = op;
        em_f3      = f3;
        em_addr    = addr;
        em_we      = we;
        em_wer     = wer;
        em_rd      = rd;
        em_regdata = regdata;
        em_dwdata  = dwdata;
    endtask

    task automatic alu_step(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        set_em(AluOp, 3'd0, 32'd0, 4'd0, 1'b1, rd, data, 32'd0);
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        set_em(LoadOp, 3'd2, 32'h100, 4'd0, 1'b1, 5'd7, 32'h77, 32'd0);
        dmem_ack = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dmem_req); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (mw_wer !== 1'b0) $display("FAIL reset_wer: got %b want 0", mw_wer); else n_pass++;
        n_checks++; if (mw_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", mw_rd); else n_pass++;
        n_checks++; if (mw_data !== 32'd0) $display("FAIL reset_data: got %h want 0", mw_data); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_buserr: got %b want 0", bus_err); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        set_em(AluOp, 3'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_add_passthrough;
        @(negedge clk);
        set_em(AluOp, 3'd0, 32'h0, 4'd0, 1'b1, 5'd5, 32'h1234, 32'd0);
        dmem_ack = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL add_req: got %b want 0", dmem_req); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL add_stall: got %b want 0", mem_stall); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (mw_wer !== 1'b1) $display("FAIL add_wer: got %b want 1", mw_wer); else n_pass++;
        n_checks++; if (mw_rd !== 5'd5) $display("FAIL add_rd: got %0d want 5", mw_rd); else n_pass++;
        n_checks++; if (mw_data !== 32'h1234) $display("FAIL add_data: got %h want 00001234", mw_data); else n_pass++;
    endtask

    task automatic test_lb_zero_wait;
        @(negedge clk);
        set_em(LoadOp, 3'd0, 32'h1003, 4'd0, 1'b1, 5'd3, 32'h0, 32'd0);
        dmem_rdata = 32'h80FF_FFFF;
        dmem_ack   = 1'b1;
        #1;
        n_checks++; if (dmem_req !== 1'b1) $display("FAIL lb_req: got %b want 1", dmem_req); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL lb_stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (dmem_addr !== 32'h1000) $display("FAIL lb_addr: got %h want 00001000", dmem_addr); else n_pass++;
        n_checks++; if (dmem_we !== 1'b0) $display("FAIL lb_we: got %b want 0", dmem_we); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (mw_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", mw_data); else n_pass++;
        n_checks++; if (mw_wer !== 1'b1) $display("FAIL lb_wer: got %b want 1", mw_wer); else n_pass++;
    endtask

    task automatic test_lhu_wait;
        int stalls;
        alu_step(5'd9, 32'h55);
        stalls = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) set_em(LoadOp, 3'd5, 32'h2002, 4'd0, 1'b1, 5'd4, 32'h0, 32'd0);
            dmem_rdata = 32'hBEEF_0000;
            dmem_ack   = (k == 3);
            #1;
            if (mem_stall) stalls++;
            @(posedge clk);
            #1;
            if (k < 3) begin
                n_checks++; if (mw_rd !== 5'd9 || mw_data !== 32'h55) $display("FAIL lhu_hold: got rd=%0d data=%h want rd=9 data=00000055", mw_rd, mw_data); else n_pass++;
            end
            if (k == 3) break;
        end
        n_checks++; if (stalls !== 3) $display("FAIL lhu_stall_cycles: got %0d want 3", stalls); else n_pass++;
        n_checks++; if (mw_data !== 32'h0000_BEEF) $display("FAIL lhu_data: got %h want 0000beef", mw_data); else n_pass++;
        n_checks++; if (mw_rd !== 5'd4 || mw_wer !== 1'b1) $display("FAIL lhu_wb: got rd=%0d wer=%b want rd=4 wer=1", mw_rd, mw_wer); else n_pass++;
    endtask

    task automatic test_sb;
        @(negedge clk);
        set_em(StoreOp, 3'd0, 32'h3001, 4'b0001, 1'b0, 5'd0, 32'h3001, 32'h0000_00AB);
        dmem_ack = 1'b1;
        #1;
        n_checks++; if (dmem_we !== 1'b1) $display("FAIL sb_we: got %b want 1", dmem_we); else n_pass++;
        n_checks++; if (dmem_be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", dmem_be); else n_pass++;
        n_checks++; if (dmem_wdata !== 32'h0000_AB00) $display("FAIL sb_wdata: got %h want 0000ab00", dmem_wdata); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL sb_stall: got %b want 0", mem_stall); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (mw_wer !== 1'b0) $display("FAIL sb_wer: got %b want 0", mw_wer); else n_pass++;
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        set_em(LoadOp, 3'd2, 32'h4002, 4'd0, 1'b1, 5'd6, 32'h0, 32'd0);
        dmem_ack = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL mis_req: got %b want 0", dmem_req); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL mis_stall: got %b want 0", mem_stall); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus_err !== 1'b1) $display("FAIL mis_buserr: got %b want 1", bus_err); else n_pass++;
        n_checks++; if (mw_wer !== 1'b0) $display("FAIL mis_wer: got %b want 0", mw_wer); else n_pass++;
        alu_step(5'd2, 32'h2);
        n_checks++; if (bus_err !== 1'b0) $display("FAIL mis_pulse: got %b want 0", bus_err); else n_pass++;
    endtask

    task automatic test_timeout;
        int stalls;
        bit released;
        stalls   = 0;
        released = 0;
        for (int k = 0; k < 20 && !released; k++) begin
            @(negedge clk);
            if (k == 0) set_em(LoadOp, 3'd2, 32'h5000, 4'd0, 1'b1, 5'd8, 32'h0, 32'd0);
            dmem_ack = 1'b0;
            #1;
            if (mem_stall) stalls++;
            else released = 1;
            @(posedge clk);
            #1;
        end
        n_checks++; if (stalls !== Timeout) $display("FAIL to_stall_cycles: got %0d want %0d", stalls, Timeout); else n_pass++;
        n_checks++; if (bus_err !== 1'b1) $display("FAIL to_buserr: got %b want 1", bus_err); else n_pass++;
        n_checks++; if (mw_wer !== 1'b0) $display("FAIL to_wer: got %b want 0", mw_wer); else n_pass++;
        // Late ack alongside a non-memory op must not disturb anything
        @(negedge clk);
        set_em(AluOp, 3'd0, 32'd0, 4'd0, 1'b1, 5'd11, 32'hC0DE, 32'd0);
        dmem_ack = 1'b1;
        #1;
        n_checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL to_late_ack: got req=%b stall=%b want 0/0", dmem_req, mem_stall); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL to_pulse: got %b want 0", bus_err); else n_pass++;
        n_checks++; if (mw_data !== 32'hC0DE || mw_wer !== 1'b1) $display("FAIL to_after: got data=%h wer=%b want 0000c0de/1", mw_data, mw_wer); else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        alu_step(5'd5, 32'h1234);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) set_em(LoadOp, 3'd2, 32'h6000, 4'd0, 1'b1, 5'd12, 32'h0, 32'd0);
            dmem_ack = 1'b0;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL rstw_comb: got req=%b stall=%b want 0/0", dmem_req, mem_stall); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (mw_wer !== 1'b0 || mw_rd !== 5'd0 || mw_data !== 32'd0) $display("FAIL rstw_mw: got wer=%b rd=%0d data=%h want 0/0/0", mw_wer, mw_rd, mw_data); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        set_em(AluOp, 3'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int n);
        logic        e_wer;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        int          kind, size, off, ack_after, sel;
        bit          mem, mis, req, stall_exp, timed, done;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  we, be_exp;
        logic        wer;
        logic [4:0]  rd;
        logic [31:0] addr, regdata, dwdata, rdata;

        alu_step(5'd1, 32'h1);
        e_wer  = 1'b1;
        e_rd   = 5'd1;
        e_data = 32'h1;
        for (int t = 0; t < n; t++) begin
            kind      = $urandom_range(0, 2);
            addr      = $urandom;
            off       = int'(addr[1:0]);
            rd        = 5'($urandom);
            regdata   = $urandom;
            dwdata    = $urandom;
            rdata     = $urandom;
            f3        = 3'($urandom);
            ack_after = $urandom_range(0, 6);
            we        = 4'd0;
            size      = 0;
            if (kind == 0) begin
                op  = AluOp;
                wer = 1'($urandom);
            end else if (kind == 1) begin
                op   = LoadOp;
                wer  = 1'b1;
                size = load_bytes(f3);
            end else begin
                op   = StoreOp;
                wer  = 1'($urandom);
                sel  = $urandom_range(0, 2);
                size = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
                we   = 4'((1 << size) - 1);
            end
            mem    = (kind != 0);
            mis    = mem && (off + size > 4);
            req    = mem && !mis;
            be_exp = 4'(((1 << size) - 1) << off);
            done   = 0;
            for (int k = 0; k <= Timeout + 1 && !done; k++) begin
                @(negedge clk);
                if (k == 0) set_em(op, f3, addr, we, wer, rd, regdata, dwdata);
                dmem_rdata = rdata;
                dmem_ack   = (k == ack_after);
                #1;
                stall_exp = req && (k != ack_after) && (k < Timeout);
                timed     = req && (k == Timeout) && (k != ack_after);
                n_checks++; if (dmem_req !== req) $display("FAIL rnd_req t=%0d k=%0d: got %b want %b", t, k, dmem_req, req); else n_pass++;
                n_checks++; if (mem_stall !== stall_exp) $display("FAIL rnd_stall t=%0d k=%0d: got %b want %b", t, k, mem_stall, stall_exp); else n_pass++;
                if (req && k == 0) begin
                    n_checks++; if (dmem_addr !== {addr[31:2], 2'b00} || dmem_be !== be_exp || dmem_we !== (kind == 2)) $display("FAIL rnd_port t=%0d: got addr=%h be=%b we=%b want addr=%h be=%b we=%b", t, dmem_addr, dmem_be, dmem_we, {addr[31:2], 2'b00}, be_exp, kind == 2); else n_pass++;
                    if (kind == 2) begin
                        n_checks++; if (dmem_wdata !== (dwdata << (8 * off))) $display("FAIL rnd_wdata t=%0d: got %h want %h", t, dmem_wdata, dwdata << (8 * off)); else n_pass++;
                    end
                end
                @(posedge clk);
                #1;
                if (!stall_exp) begin
                    e_wer  = wer && !mis && !timed;
                    e_rd   = rd;
                    e_data = (kind == 1) ? ref_load(rdata, off, f3) : regdata;
                    done   = 1;
                end
                n_checks++; if (mw_wer !== e_wer || mw_rd !== e_rd || mw_data !== e_data) $display("FAIL rnd_mw t=%0d k=%0d: got wer=%b rd=%0d data=%h want wer=%b rd=%0d data=%h", t, k, mw_wer, mw_rd, mw_data, e_wer, e_rd, e_data); else n_pass++;
                n_checks++; if (bus_err !== (!stall_exp && (mis || timed))) $display("FAIL rnd_buserr t=%0d k=%0d: got %b want %b", t, k, bus_err, !stall_exp && (mis || timed)); else n_pass++;
            end
            if (!done) begin
                n_checks++;
                $display("FAIL rnd_budget t=%0d: transaction did not complete within %0d cycles", t, Timeout + 2);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        set_em(AluOp, 3'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        test_reset;
        test_add_passthrough;
        test_lb_zero_wait;
        test_lhu_wait;
        test_sb;
        test_misaligned;
        test_timeout;
        test_reset_mid_wait;
        test_random(200);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
